// File: rtl/dff_bank_universal.sv
// dff_bank_universal: WIDTH-bit D flip-flop bank with hold/shift-right/shift-left/load modes.
// Define DFF_BANK_UNIVERSAL_ROTATE_EN to turn both shifts into rotates.
module dff_bank_universal #(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             input_clock1_1,
    input  logic             input_reset1_2,
    input  logic             input_enable_3,
    input  logic [1:0]       input_mode_4,
    input  logic [WIDTH-1:0] input_data_5,
    input  logic             input_serial_msb_6,
    input  logic             input_serial_lsb_7,
    output logic [WIDTH-1:0] output_q_8,
    output logic [WIDTH-1:0] output_qn_9,
    output logic             output_shift_out_10,
    output logic             output_changed_11
);
`ifdef DFF_BANK_UNIVERSAL_ROTATE_EN
    localparam logic ROTATE = 1'b1;
`else
    localparam logic ROTATE = 1'b0;
`endif
    logic [WIDTH-1:0] q_q = RESET_VALUE;
    logic             shift_out_q = 1'b0;
    logic             changed_q = 1'b0;
    logic [WIDTH-1:0] q_d, shr, shl;
    logic             shift_out_d, changed_d, fill_r, fill_l;
    // Single-bit overwrite after the shift keeps WIDTH=1 legal without a slice.
    always_comb begin
        fill_r = ROTATE ? q_q[0] : input_serial_msb_6;
        fill_l = ROTATE ? q_q[WIDTH-1] : input_serial_lsb_7;
        shr = q_q >> 1;
        shr[WIDTH-1] = fill_r;
        shl = q_q << 1;
        shl[0] = fill_l;
        q_d = !input_enable_3       ? q_q :
              input_mode_4 == 2'b01 ? shr :
              input_mode_4 == 2'b10 ? shl :
              input_mode_4 == 2'b11 ? input_data_5 : q_q;
        shift_out_d = !input_enable_3       ? shift_out_q :
                      input_mode_4 == 2'b01 ? q_q[0] :
                      input_mode_4 == 2'b10 ? q_q[WIDTH-1] : shift_out_q;
        changed_d = q_d != q_q;
    end
    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            q_q <= RESET_VALUE;
            shift_out_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q <= q_d;
            shift_out_q <= shift_out_d;
            changed_q <= changed_d;
        end
    end
    assign output_q_8 = q_q;
    assign output_qn_9 = ~q_q;
    assign output_shift_out_10 = shift_out_q;
    assign output_changed_11 = changed_q;
endmodule

// File: tb/tb_dff_bank_universal.sv
// tb_dff_bank_universal: scoreboard bench for dff_bank_universal (WIDTH=4, RESET_VALUE=1010).
module tb_dff_bank_universal;
    localparam logic [3:0] RV = 4'b1010;
`ifdef DFF_BANK_UNIVERSAL_ROTATE_EN
    localparam logic ROT = 1'b1;
`else
    localparam logic ROT = 1'b0;
`endif
    typedef struct packed {
        logic [3:0] q;
        logic       so;
        logic       ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en, msb, lsb;
    logic [1:0] mode;
    logic [3:0] data, q, qn;
    logic so, ch;
    exp_t sb[$];
    exp_t e;
    logic [3:0] m_q = RV;
    logic m_so = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dff_bank_universal #(.WIDTH(4), .RESET_VALUE(RV)) dut (
        .input_clock1_1(clk),
        .input_reset1_2(rst),
        .input_enable_3(en),
        .input_mode_4(mode),
        .input_data_5(data),
        .input_serial_msb_6(msb),
        .input_serial_lsb_7(lsb),
        .output_q_8(q),
        .output_qn_9(qn),
        .output_shift_out_10(so),
        .output_changed_11(ch)
    );

    // Drives one cycle, predicts the result bit by bit, and queues it.
    task automatic drive(input logic r, input logic n, input logic [1:0] md,
                         input logic [3:0] d, input logic sm, input logic sl);
        logic [3:0] nq;
        logic nso;
        rst = r; en = n; mode = md; data = d; msb = sm; lsb = sl;
        nq = m_q;
        nso = m_so;
        if (r) begin
            nq = RV;
            nso = 1'b0;
        end else if (n && md == 2'b01) begin
            for (int i = 0; i < 3; i++) nq[i] = m_q[i+1];
            nq[3] = ROT ? m_q[0] : sm;
            nso = m_q[0];
        end else if (n && md == 2'b10) begin
            for (int i = 1; i < 4; i++) nq[i] = m_q[i-1];
            nq[0] = ROT ? m_q[3] : sl;
            nso = m_q[3];
        end else if (n && md == 2'b11) begin
            nq = d;
        end
        sb.push_back('{q: nq, so: nso, ch: !r && (nq != m_q)});
        m_q = nq;
        m_so = nso;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 2'b11, 4'b0101, 1'b1, 1'b1);
            e = sb.pop_front();
            total++;
            if ({q, qn, so, ch} !== {e.q, ~e.q, e.so, e.ch}) begin
                bad++;
                $display("FAIL reset%0d got q=%b qn=%b so=%b ch=%b want q=%b qn=%b so=%b ch=%b",
                         k, q, qn, so, ch, e.q, ~e.q, e.so, e.ch);
            end
        end
    endtask

    task automatic test_shift_right();
        drive(1'b0, 1'b1, 2'b11, 4'b0110, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) drive(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0);
            e = sb.pop_front();
            total++;
            if ({q, qn, so, ch} !== {e.q, ~e.q, e.so, e.ch}) begin
                bad++;
                $display("FAIL shr%0d got q=%b qn=%b so=%b ch=%b want q=%b so=%b ch=%b",
                         k, q, qn, so, ch, e.q, e.so, e.ch);
            end
        end
    endtask

    task automatic test_shift_left();
        drive(1'b0, 1'b1, 2'b11, 4'b1001, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) drive(1'b0, 1'b1, 2'b10, 4'b0000, 1'b1, k == 3);
            e = sb.pop_front();
            total++;
            if ({q, qn, so, ch} !== {e.q, ~e.q, e.so, e.ch}) begin
                bad++;
                $display("FAIL shl%0d got q=%b qn=%b so=%b ch=%b want q=%b so=%b ch=%b",
                         k, q, qn, so, ch, e.q, e.so, e.ch);
            end
        end
    endtask

    task automatic test_enable();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, k >= 3, 2'b11, 4'b1111, 1'b0, 1'b0);
            e = sb.pop_front();
            total++;
            if ({q, qn, so, ch} !== {e.q, ~e.q, e.so, e.ch}) begin
                bad++;
                $display("FAIL enable%0d got q=%b qn=%b so=%b ch=%b want q=%b so=%b ch=%b",
                         k, q, qn, so, ch, e.q, e.so, e.ch);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 2'b11, 4'b0101, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            total++;
            if (k == 2 && {q, qn, so, ch} !== {e.q, ~e.q, e.so, e.ch}) begin
                bad++;
                $display("FAIL mid_reset got q=%b qn=%b so=%b ch=%b want q=%b so=%b ch=%b",
                         q, qn, so, ch, e.q, e.so, e.ch);
            end
        end
        total -= 2;
    endtask

    task automatic test_rotate();
        drive(1'b0, 1'b1, 2'b11, 4'b0001, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) drive(1'b0, 1'b1, 2'b01, 4'b0000, 1'($urandom_range(1)), 1'($urandom_range(1)));
            e = sb.pop_front();
            total++;
            if ({q, qn, so, ch} !== {e.q, ~e.q, e.so, e.ch}) begin
                bad++;
                $display("FAIL rot%0d got q=%b qn=%b so=%b ch=%b want q=%b so=%b ch=%b",
                         k, q, qn, so, ch, e.q, e.so, e.ch);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            drive($urandom_range(19) == 0, $urandom_range(5) != 0, 2'($urandom_range(3)),
                  4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            e = sb.pop_front();
            total++;
            if ({q, qn, so, ch} !== {e.q, ~e.q, e.so, e.ch}) begin
                bad++;
                $display("FAIL b2b%0d got q=%b qn=%b so=%b ch=%b want q=%b so=%b ch=%b",
                         k, q, qn, so, ch, e.q, e.so, e.ch);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; data = 4'b0000; msb = 1'b0; lsb = 1'b0;
        #1;
        test_reset();
        test_shift_right();
        test_shift_left();
        test_enable();
        test_mid_reset();
        test_rotate();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
